scan_sched: RTL and testbench



---
 rtl/scan_sched.sv | 193 +++++++++++++++++++
 tb/tb_scan_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sched.sv
// scan_sched: shares one serial Moore sequence detector between two requesters.
// Each accepted word is shifted MSB-first into the detector after a one-cycle
// detector clear. The cycles with det_y high are counted, and the count is
// returned tagged with the requester id. Arbitration is round-robin, and the
// fairness pointer moves only on a grant.
// Optional build macro SCAN_FIRST_HIT_EN adds res_first: the index of the
// first sample with det_y=1, or WIDTH when no sample hit.
module scan_sched #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             det_x,
  output logic             det_rst_n,
  input  logic             det_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
`ifdef SCAN_FIRST_HIT_EN
  output logic [CW-1:0]    res_first,
`endif
  output logic [CW-1:0]    res_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0]    hit_q, hit_d;
  logic             id_q, id_d;

  logic             grant_any;
  logic             grant_id;
  logic [1:0]       grant_oh;
  logic [WIDTH-1:0] sel_data;

  // Round-robin arbitration: a lone requester wins outright; on a tie the
  // pointer decides.
  always_comb begin
    grant_any = req_valid[0] | req_valid[1];
    if (req_valid == 2'b11) begin
      grant_id = ptr_q;
    end else begin
      grant_id = req_valid[1];
    end
    if (grant_any) begin
      grant_oh = grant_id ? 2'b10 : 2'b01;
    end else begin
      grant_oh = 2'b00;
    end
    sel_data = grant_id ? req_data1 : req_data0;
  end

  // Ready only in IDLE, and never while reset is asserted, so no word can be
  // taken during reset.
  assign req_ready = (rst_n && (state_q == S_IDLE)) ? grant_oh : 2'b00;

  // The detector is cleared in CLR and is also held in reset while this block is.
  assign det_rst_n = rst_n && (state_q != S_CLR);

  // The serial bit is the shift-register MSB, driven only while shifting.
  assign det_x = rst_n && (state_q == S_SHIFT) && shreg_q[WIDTH-1];

  assign res_valid = (state_q == S_DONE);
  assign res_id    = id_q;
  assign res_count = hit_q;

  // Scan sequencing. SHIFT cycle 0 is not sampled: det_y still shows the
  // cleared state there. DRAIN then picks up the detector state after the
  // last bit, giving exactly WIDTH samples.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    hit_d    = hit_q;
    id_d     = id_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          shreg_d = sel_data;
          id_d    = grant_id;
          ptr_d   = ~grant_id;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        hit_d    = '0;
        bitcnt_d = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if ((bitcnt_q != '0) && det_y) begin
          hit_d = hit_q + CW'(1);
        end
        if (bitcnt_q == LAST_BIT) begin
          state_d = S_DRAIN;
        end else begin
          bitcnt_d = bitcnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (det_y) begin
          hit_d = hit_q + CW'(1);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and scan registers; reset aborts any scan in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      hit_q    <= '0;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      hit_q    <= hit_d;
      id_q     <= id_d;
    end
  end

`ifdef SCAN_FIRST_HIT_EN
  logic [CW-1:0] first_q, first_d;
  logic          found_q, found_d;
  logic          sample_en;
  logic [CW-1:0] sample_idx;

  // The first hit is captured once per scan. Sample j is taken in SHIFT
  // cycle j+1, or in DRAIN for the last sample. A scan with no hit ends
  // with WIDTH.
  always_comb begin
    first_d    = first_q;
    found_d    = found_q;
    sample_en  = ((state_q == S_SHIFT) && (bitcnt_q != '0)) || (state_q == S_DRAIN);
    sample_idx = (state_q == S_DRAIN) ? LAST_BIT : (bitcnt_q - CW'(1));
    if (state_q == S_CLR) begin
      first_d = '0;
      found_d = 1'b0;
    end else if (sample_en && !found_q) begin
      if (det_y) begin
        first_d = sample_idx;
        found_d = 1'b1;
      end else if (state_q == S_DRAIN) begin
        first_d = CW'(WIDTH);
      end
    end
  end

  // First-hit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q <= '0;
      found_q <= 1'b0;
    end else begin
      first_q <= first_d;
      found_q <= found_d;
    end
  end

  assign res_first = first_q;
`endif

endmodule

// File: tb/tb_scan_sched.sv
// Bench for scan_sched. It contains a behavioural detector model (a table-driven
// Moore machine), a timeline model of the scheduler checked on every cycle,
// and directed scenarios with literal expectations.
module tb_scan_sched;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [WIDTH-1:0] req_data0 = '0;
  logic [WIDTH-1:0] req_data1 = '0;
  logic [1:0]       req_ready;
  logic             det_x;
  logic             det_rst_n;
  logic             det_y;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             res_id;
  logic [CW-1:0]    res_count;
`ifdef SCAN_FIRST_HIT_EN
  logic [CW-1:0]    res_first;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  scan_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data0(req_data0),
    .req_data1(req_data1),
    .req_ready(req_ready),
    .det_x(det_x),
    .det_rst_n(det_rst_n),
    .det_y(det_y),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_id(res_id),
`ifdef SCAN_FIRST_HIT_EN
    .res_first(res_first),
`endif
    .res_count(res_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Detector: S0=0 A=1 B=2 C=3 D=4 E=5, with y=1 only in B.
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return 3'd2;
      3'd2:    return b ? 3'd4 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd2;
      3'd4:    return b ? 3'd5 : 3'd0;
      3'd5:    return b ? 3'd2 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0] dstate = 3'd0;
  assign det_y = (dstate == 3'd2);
  always @(posedge clk) begin
    if (!det_rst_n) dstate <= 3'd0;
    else            dstate <= det_next(dstate, det_x);
  end

  // Expected result of scanning one word through a freshly cleared detector.
  function automatic void exp_scan(input logic [WIDTH-1:0] w, output int cnt, output int fst);
    logic [2:0]       s;
    logic [WIDTH-1:0] v;
    s   = 3'd0;
    v   = w;
    cnt = 0;
    fst = WIDTH;
    for (int k = 0; k < WIDTH; k++) begin
      s = det_next(s, v[WIDTH-1]);
      v = v << 1;
      if (s == 3'd2) begin
        cnt++;
        if (fst == WIDTH) fst = k;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model. In each accepted job, cycle t0 is the accept cycle,
  // t0+1 clears the detector, t0+2..t0+WIDTH+1 carry the bits, t0+WIDTH+2
  // drains, and the result is valid from t0+WIDTH+3 until it is taken.
  bit               m_live = 0;
  bit               m_prev_rst = 0;
  bit               m_busy = 0;
  bit               m_ptr = 0;
  bit               m_id = 0;
  int               m_t0 = 0;
  int               m_cnt = 0;
  int               m_first = 0;
  logic [WIDTH-1:0] m_word = '0;

  always @(negedge clk) begin : cmp
    int               d;
    bit               g;
    logic [1:0]       exp_rdy;
    logic [WIDTH-1:0] sh;
    if (!rst_n) begin
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_det_rst_n", 32'(det_rst_n), 0);
      check("rst_det_x", 32'(det_x), 0);
      if (m_prev_rst) check("rst_res_valid", 32'(res_valid), 0);
      m_busy = 0;
      m_ptr = 0;
      m_live = 1;
      m_prev_rst = 1;
    end else if (m_live) begin
      m_prev_rst = 0;
      if (!m_busy) begin
        check("idle_res_valid", 32'(res_valid), 0);
        check("idle_det_rst_n", 32'(det_rst_n), 1);
        g = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        exp_rdy = (req_valid == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01);
        check("idle_req_ready", 32'(req_ready), 32'(exp_rdy));
        if (req_valid != 2'b00) begin
          m_busy = 1;
          m_t0 = cyc;
          m_id = g;
          m_ptr = !g;
          m_word = g ? req_data1 : req_data0;
          exp_scan(m_word, m_cnt, m_first);
        end
      end else begin
        d = cyc - m_t0;
        check("busy_req_ready", 32'(req_ready), 0);
        check("det_rst_n", 32'(det_rst_n), (d == 1) ? 0 : 1);
        if (d == 1 || d == WIDTH + 2) begin
          check("det_x_quiet", 32'(det_x), 0);
        end else if (d >= 2 && d <= WIDTH + 1) begin
          sh = m_word << (d - 2);
          check("det_x_bit", 32'(det_x), 32'(sh[WIDTH-1]));
        end
        if (d >= WIDTH + 3) begin
          check("res_valid", 32'(res_valid), 1);
          check("res_id", 32'(res_id), 32'(m_id));
          check("res_count", 32'(res_count), m_cnt);
`ifdef SCAN_FIRST_HIT_EN
          check("res_first", 32'(res_first), m_first);
`endif
          if (res_ready) m_busy = 0;
        end else begin
          check("res_valid_early", 32'(res_valid), 0);
        end
      end
    end
  end

  task automatic submit(input int idx, input logic [WIDTH-1:0] w, output int acc);
    bit seen;
    seen = 0;
    acc = -1;
    if (idx == 0) begin req_data0 = w; req_valid[0] = 1'b1; end
    else          begin req_data1 = w; req_valid[1] = 1'b1; end
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if ((idx == 0) ? req_ready[0] : req_ready[1]) begin
        acc = cyc;
        seen = 1;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL submit_timeout: requester %0d got no ready, expected ready within 60 cycles", idx);
    end
    @(posedge clk); #1;
    if (idx == 0) req_valid[0] = 1'b0;
    else          req_valid[1] = 1'b0;
  endtask

  task automatic wait_result(output int id, output int cnt, output int fst, output int at);
    bit seen;
    seen = 0;
    at = -1; id = -1; cnt = -1; fst = -1;
    @(posedge clk);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) begin
        id = 32'(res_id);
        cnt = 32'(res_count);
`ifdef SCAN_FIRST_HIT_EN
        fst = 32'(res_first);
`endif
        at = cyc;
        seen = 1;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: got no res_valid, expected one within 60 cycles");
    end
  endtask

  task automatic check_first(input string name, input int fst, input int exp);
`ifdef SCAN_FIRST_HIT_EN
    check(name, fst, exp);
`endif
  endtask

  initial begin
    int acc, id, cnt, fst, at, c, f;

    // Model pins: hand-derived detector responses.
    exp_scan(8'h80, c, f); check("model_80_cnt", c, 4); check("model_80_first", f, 1);
    exp_scan(8'hFF, c, f); check("model_ff_cnt", c, 3); check("model_ff_first", f, 1);
    exp_scan(8'h00, c, f); check("model_00_cnt", c, 0); check("model_00_first", f, 8);

    // Reset held with both requesters valid.
    rst_n = 1'b0;
    req_data0 = 8'h80;
    req_data1 = 8'h80;
    req_valid = 2'b11;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_ready", 32'(req_ready), 0);
      check("rst_hold_res_valid", 32'(res_valid), 0);
      check("rst_hold_det_rst_n", 32'(det_rst_n), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_r0", 32'(req_ready), 1);
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_result(id, cnt, fst, at);
    check("post_rst_id", id, 0);
    check("post_rst_cnt", cnt, 4);
    check("post_rst_lat", at - acc, WIDTH + 3);

    // Single scan of 8'h80 from requester 0.
    submit(0, 8'h80, acc);
    wait_result(id, cnt, fst, at);
    check("single_id", id, 0);
    check("single_cnt", cnt, 4);
    check("single_lat", at - acc, 11);
    check_first("single_first", fst, 1);

    // Patterns.
    submit(0, 8'h00, acc);
    wait_result(id, cnt, fst, at);
    check("zero_id", id, 0);
    check("zero_cnt", cnt, 0);
    check_first("zero_first", fst, 8);
    submit(1, 8'hFF, acc);
    wait_result(id, cnt, fst, at);
    check("ones_id", id, 1);
    check("ones_cnt", cnt, 3);
    check("ones_lat", at - acc, 11);
    check_first("ones_first", fst, 1);

    // Round-robin with both requesters valid continuously.
    req_data0 = 8'h80;
    req_data1 = 8'h80;
    req_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
      wait_result(id, cnt, fst, at);
      check("rr_id", id, r % 2);
      check("rr_cnt", cnt, 4);
      if (r == 3) begin
        @(posedge clk); #1;
        req_valid = 2'b00;
      end
    end

    // Backpressure: result held for 5 DONE cycles while requester 1 waits.
    res_ready = 1'b0;
    submit(0, 8'h80, acc);
    req_data1 = 8'h80;
    req_valid = 2'b10;
    wait_result(id, cnt, fst, at);
    check("bp_id", id, 0);
    check("bp_cnt", cnt, 4);
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(res_valid), 1);
      check("bp_hold_id", 32'(res_id), 0);
      check("bp_hold_cnt", 32'(res_count), 4);
      check("bp_hold_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(res_valid), 1);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 2);
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_result(id, cnt, fst, at);
    check("bp_r1_id", id, 1);
    check("bp_r1_cnt", cnt, 4);
    check("bp_r1_lat", at - acc, 11);

    // Reset during SHIFT cycle 3 aborts the scan.
    submit(0, 8'h80, acc);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_res_valid", 32'(res_valid), 0);
    check("abort_det_rst_n", 32'(det_rst_n), 1);
    check("abort_ready_idle", 32'(req_ready), 0);
    submit(0, 8'h80, acc);
    wait_result(id, cnt, fst, at);
    check("resub_id", id, 0);
    check("resub_cnt", cnt, 4);
    check("resub_lat", at - acc, 11);
    check_first("resub_first", fst, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
